stim_loader: RTL and testbench
==============================

STIM_LOADER -- requirements
Module: stim_loader

Interface
REQ-001 Parameter STF_WIDTH, default 24: stimulus data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter CYCLE_RANGE, default 5: cycle-count field width.
REQ-003 Parameter CMD_EXT_WIDTH, default 8: DI command width (REQ+CMD bits).
REQ-004 One clock; reset is asynchronous and active-high. Ports are clock and reset.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 in_data  in  8  host byte stream.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  block accepts a byte this cycle.
REQ-010 sfifo_data  out  STF_WIDTH+CYCLE_RANGE+1  stimulus word {data, cycle_count, mode}.
REQ-011 sfifo_wrreq  out  1  stimulus FIFO write strobe.
REQ-012 sfifo_wrfull  in  1  stimulus FIFO full.
REQ-013 dififo_data  out  CMD_EXT_WIDTH+STF_WIDTH  DI word {cmd, data}.
REQ-014 dififo_wrreq  out  1  DI FIFO write strobe.
REQ-015 dififo_wrfull  in  1  DI FIFO full.
REQ-016 stim_count  out  16  stimulus words written, wraps at 2^16.
REQ-017 err_count  out  8  discarded headers, saturates at 255.
REQ-018 busy  out  1  high when state is not HDR.

Function
REQ-019 Byte transfer SHALL occur only on a rising edge with in_valid & in_ready both high.
REQ-020 States: HDR, CMD, DATA, WRITE. in_ready SHALL be high in HDR, CMD and DATA, and low in WRITE.
REQ-021 HDR with header bit7=0 (stimulus): latch mode=bit6 and cycle_count=bits[CYCLE_RANGE-1:0], ignore bit5 -> DATA, target=SFIFO.
REQ-022 HDR with header 0x80 (command): -> CMD, target=DIFIFO.
REQ-023 HDR with bit7=1 and bits[6:0]!=0: discard the byte, increment err_count (saturating), stay in HDR.
REQ-024 CMD: latch the byte as cmd -> DATA.
REQ-025 DATA: accept STF_WIDTH/8 bytes MSB first, shifting into the data register; after the last byte -> WRITE.
REQ-026 WRITE: assert the target wrreq combinationally while its wrfull=0, then -> HDR on the same edge. Hold while wrfull=1, with data stable and wrreq low.
REQ-027 The non-target wrreq SHALL stay low. sfifo_wrreq and dififo_wrreq SHALL never both be high.
REQ-028 Latency: last data byte accepted on edge N; wrreq high in cycle N+1 if not full; next header byte accepted no earlier than edge N+2.
REQ-029 sfifo_data SHALL equal {data, cycle_count, mode}, and dififo_data SHALL equal {cmd, data}. Both are held from entry to WRITE until the next WRITE.
REQ-030 stim_count SHALL increment by 1 on each sfifo write, modulo 2^16.
REQ-031 in_valid low in any state: no state change, no partial-byte effect.
REQ-032 wrfull SHALL be sampled only in WRITE; full during HDR, CMD or DATA SHALL not stall byte acceptance.
REQ-033 No timeout: a partial packet waits indefinitely for bytes.

Reset
REQ-034 While reset is high, state SHALL be HDR, and all data/cmd/mode/cycle registers, sfifo_data, dififo_data, stim_count and err_count SHALL be 0.
REQ-035 While reset is high, sfifo_wrreq and dififo_wrreq SHALL be 0, busy SHALL be 0, and in_ready SHALL be 1 (combinational from state HDR).
REQ-036 Reset mid-packet SHALL discard the partial packet with no FIFO write; the first byte after release SHALL be parsed as a header.

Verification
REQ-037 Bytes 0x45,0x12,0x34,0x56, FIFOs not full -> one sfifo_wrreq pulse; sfifo_data = {24'h123456, 5'd5, 1'b1}; stim_count=1.
REQ-038 Bytes 0x80,0x01,0x00,0x00,0x0F -> one dififo_wrreq pulse; dififo_data = {8'h01, 24'h00000F}; sfifo_wrreq stays 0; stim_count unchanged.
REQ-039 sfifo_wrfull=1 before the last byte of 0x00,0xAA,0xBB,0xCC -> WRITE held, in_ready=0 and wrreq=0 for 10 cycles; wrfull drops -> single write of {24'hAABBCC, 5'd0, 1'b0}.
REQ-040 Byte 0x81, then 0x02,0x01,0x02,0x03 -> err_count=1; one write {24'h010203, 5'd2, 1'b0}.
REQ-041 300 bytes of 0xFF -> err_count saturates at 255, no FIFO writes, busy=0 throughout.
REQ-042 Reset asserted after 0x45,0x12 -> no write; after release, 0x00,0x01,0x02,0x03 -> one write of {24'h010203, 5'd0, 1'b0}; stim_count=1.

Source files
------------

// File: rtl/stim_loader.sv
// Host byte-stream parser: splits headered packets into stimulus words (SFIFO)
// and DI command words (DIFIFO), with write-hold on full and header error counting.
module stim_loader #(
  parameter int unsigned STF_WIDTH     = 24,
  parameter int unsigned CYCLE_RANGE   = 5,
  parameter int unsigned CMD_EXT_WIDTH = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [7:0]                           in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [STF_WIDTH+CYCLE_RANGE:0]       sfifo_data,
  output logic                                 sfifo_wrreq,
  input  logic                                 sfifo_wrfull,
  output logic [CMD_EXT_WIDTH+STF_WIDTH-1:0]   dififo_data,
  output logic                                 dififo_wrreq,
  input  logic                                 dififo_wrfull,
  output logic [15:0]                          stim_count,
  output logic [7:0]                           err_count,
  output logic                                 busy
);

  localparam int unsigned NumBytes = STF_WIDTH / 8;
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [CntW-1:0] LastByte = CntW'(NumBytes - 1);

  typedef enum logic [1:0] {
    StHdr,
    StCmd,
    StData,
    StWrite
  } state_e;

  state_e                            state_q, state_d;
  logic [STF_WIDTH-1:0]              data_q, data_d;
  logic [CMD_EXT_WIDTH-1:0]          cmd_q, cmd_d;
  logic                              mode_q, mode_d;
  logic [CYCLE_RANGE-1:0]            cyc_q, cyc_d;
  logic                              tgt_di_q, tgt_di_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [STF_WIDTH+CYCLE_RANGE:0]    sfifo_data_q, sfifo_data_d;
  logic [CMD_EXT_WIDTH+STF_WIDTH-1:0] dififo_data_q, dififo_data_d;
  logic [15:0]                       stim_count_q, stim_count_d;
  logic [7:0]                        err_count_q, err_count_d;

  logic                              accept;
  logic [STF_WIDTH-1:0]              data_shift;

  // MSB-first: each new byte enters at the bottom, the oldest falls off the top.
  assign data_shift = STF_WIDTH'({data_q, in_data});

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    cmd_d         = cmd_q;
    mode_d        = mode_q;
    cyc_d         = cyc_q;
    tgt_di_d      = tgt_di_q;
    cnt_d         = cnt_q;
    sfifo_data_d  = sfifo_data_q;
    dififo_data_d = dififo_data_q;
    stim_count_d  = stim_count_q;
    err_count_d   = err_count_q;
    sfifo_wrreq   = 1'b0;
    dififo_wrreq  = 1'b0;
    in_ready      = (state_q != StWrite);
    busy          = (state_q != StHdr);
    accept        = in_valid & in_ready;

    unique case (state_q)
      StHdr: begin
        if (accept) begin
          cnt_d = '0;
          if (!in_data[7]) begin
            mode_d   = in_data[6];
            cyc_d    = in_data[CYCLE_RANGE-1:0];
            tgt_di_d = 1'b0;
            state_d  = StData;
          end else if (in_data[6:0] == 7'd0) begin
            tgt_di_d = 1'b1;
            state_d  = StCmd;
          end else if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
      end
      StCmd: begin
        if (accept) begin
          cmd_d   = CMD_EXT_WIDTH'(in_data);
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          data_d = data_shift;
          if (cnt_q == LastByte) begin
            sfifo_data_d  = {data_shift, cyc_q, mode_q};
            dififo_data_d = {cmd_q, data_shift};
            state_d       = StWrite;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWrite: begin
        // Only the target FIFO's full flag matters, and only here.
        if (tgt_di_q) begin
          if (!dififo_wrfull) begin
            dififo_wrreq = 1'b1;
            state_d      = StHdr;
          end
        end else if (!sfifo_wrfull) begin
          sfifo_wrreq  = 1'b1;
          stim_count_d = stim_count_q + 16'd1;
          state_d      = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StHdr;
      data_q        <= '0;
      cmd_q         <= '0;
      mode_q        <= 1'b0;
      cyc_q         <= '0;
      tgt_di_q      <= 1'b0;
      cnt_q         <= '0;
      sfifo_data_q  <= '0;
      dififo_data_q <= '0;
      stim_count_q  <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      cmd_q         <= cmd_d;
      mode_q        <= mode_d;
      cyc_q         <= cyc_d;
      tgt_di_q      <= tgt_di_d;
      cnt_q         <= cnt_d;
      sfifo_data_q  <= sfifo_data_d;
      dififo_data_q <= dififo_data_d;
      stim_count_q  <= stim_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign sfifo_data  = sfifo_data_q;
  assign dififo_data = dififo_data_q;
  assign stim_count  = stim_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_stim_loader.sv
// Self-checking bench for stim_loader: scoreboard queues for both FIFO ports,
// one task per scenario.
module tb_stim_loader;

  localparam int unsigned SW = 24;
  localparam int unsigned CR = 5;
  localparam int unsigned CW = 8;

  logic                clk;
  logic                rst;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [SW+CR:0]      sfifo_data;
  logic                sfifo_wrreq;
  logic                sfifo_wrfull;
  logic [CW+SW-1:0]    dififo_data;
  logic                dififo_wrreq;
  logic                dififo_wrfull;
  logic [15:0]         stim_count;
  logic [7:0]          err_count;
  logic                busy;

  int n_checks = 0;
  int n_fails  = 0;
  int n_swr    = 0;
  int n_dwr    = 0;

  logic [SW+CR:0]   sq[$];
  logic [CW+SW-1:0] dq[$];

  stim_loader #(
    .STF_WIDTH    (SW),
    .CYCLE_RANGE  (CR),
    .CMD_EXT_WIDTH(CW)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sfifo_data   (sfifo_data),
    .sfifo_wrreq  (sfifo_wrreq),
    .sfifo_wrfull (sfifo_wrfull),
    .dififo_data  (dififo_data),
    .dififo_wrreq (dififo_wrreq),
    .dififo_wrfull(dififo_wrfull),
    .stim_count   (stim_count),
    .err_count    (err_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write strobe pops one expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (sfifo_wrreq && dififo_wrreq) begin
        n_checks++; n_fails++;
        $display("FAIL both_wrreq: sfifo_wrreq=1 dififo_wrreq=1, required at most one");
      end
      if (sfifo_wrreq) begin
        n_swr++;
        n_checks++;
        if (sq.size() == 0) begin
          n_fails++;
          $display("FAIL sfifo_unexpected: write of %h, none expected", sfifo_data);
        end else begin
          logic [SW+CR:0] e;
          e = sq.pop_front();
          if (sfifo_data !== e) begin
            n_fails++;
            $display("FAIL sfifo_data: got %h, required %h", sfifo_data, e);
          end
        end
      end
      if (dififo_wrreq) begin
        n_dwr++;
        n_checks++;
        if (dq.size() == 0) begin
          n_fails++;
          $display("FAIL dififo_unexpected: write of %h, none expected", dififo_data);
        end else begin
          logic [CW+SW-1:0] e;
          e = dq.pop_front();
          if (dififo_data !== e) begin
            n_fails++;
            $display("FAIL dififo_data: got %h, required %h", dififo_data, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++; n_fails++;
      $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sq.size() != 0 || dq.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (sq.size() != 0 || dq.size() != 0) begin
      n_fails++;
      $display("FAIL %s_drain: %0d/%0d writes pending, required 0/0", name, sq.size(), dq.size());
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] req);
    n_checks++;
    if (got !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, busy, sfifo_wrreq, dififo_wrreq} !== 4'b1000) begin
      n_fails++;
      $display("FAIL reset_ctrl: {rdy,busy,swr,dwr}=%b, required 1000",
               {in_ready, busy, sfifo_wrreq, dififo_wrreq});
    end
    n_checks++;
    if (sfifo_data !== '0 || dififo_data !== '0) begin
      n_fails++;
      $display("FAIL reset_data: sfifo=%h difi=%h, required 0", sfifo_data, dififo_data);
    end
    check16("reset_stim_count", stim_count, 16'd0);
    check16("reset_err_count", {8'd0, err_count}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stim();
    logic [7:0] pkt[4];
    pkt = '{8'h45, 8'h12, 8'h34, 8'h56};
    sq.push_back({24'h123456, 5'd5, 1'b1});
    for (int i = 0; i < 4; i++) begin
      send_byte(pkt[i]);
      // Idle gap with garbage on the bus must not disturb the parse.
      repeat (3) @(posedge clk);
      #1;
    end
    drain("stim");
    check16("stim_count_1", stim_count, 16'd1);
  endtask

  task automatic test_cmd();
    logic [7:0] pkt[5];
    int s0;
    s0 = n_swr;
    pkt = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h0F};
    dq.push_back({8'h01, 24'h00000F});
    // Full flags outside WRITE must not stall acceptance.
    sfifo_wrfull  = 1'b1;
    dififo_wrfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) dififo_wrfull = 1'b0;
      send_byte(pkt[i]);
    end
    sfifo_wrfull = 1'b0;
    drain("cmd");
    check16("cmd_stim_count", stim_count, 16'd1);
    check16("cmd_no_sfifo", 16'(n_swr - s0), 16'd0);
  endtask

  task automatic test_full();
    int bad;
    bad = 0;
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    sfifo_wrfull = 1'b1;
    send_byte(8'hCC);
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0 || sfifo_wrreq !== 1'b0 || busy !== 1'b1 ||
          sfifo_data !== {24'hAABBCC, 5'd0, 1'b0}) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL full_hold: %0d bad hold cycles, required 0", bad);
    end
    sq.push_back({24'hAABBCC, 5'd0, 1'b0});
    sfifo_wrfull = 1'b0;
    drain("full");
    check16("full_stim_count", stim_count, 16'd2);
  endtask

  task automatic test_err();
    send_byte(8'h81);
    check16("err_count_1", {8'd0, err_count}, 16'd1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL err_busy: got %b, required 0", busy);
    end
    sq.push_back({24'h010203, 5'd2, 1'b0});
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    drain("err");
    check16("err_count_hold", {8'd0, err_count}, 16'd1);
    check16("err_stim_count", stim_count, 16'd3);
  endtask

  task automatic test_back_to_back();
    sq.push_back({24'hFEDCBA, 5'd31, 1'b1});
    send_byte(8'h7F);
    send_byte(8'hFE);
    send_byte(8'hDC);
    send_byte(8'hBA);
    // Cycle after the last byte edge: strobe up, input stalled.
    n_checks++;
    if ({sfifo_wrreq, in_ready, busy} !== 3'b101) begin
      n_fails++;
      $display("FAIL b2b_latency: {swr,rdy,busy}=%b, required 101",
               {sfifo_wrreq, in_ready, busy});
    end
    dq.push_back({8'hC3, 24'h5A5A5A});
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'h5A);
    n_checks++;
    if ({dififo_wrreq, sfifo_wrreq} !== 2'b10) begin
      n_fails++;
      $display("FAIL b2b_di_latency: {dwr,swr}=%b, required 10", {dififo_wrreq, sfifo_wrreq});
    end
    drain("b2b");
    check16("b2b_stim_count", stim_count, 16'd4);
  endtask

  task automatic test_saturate();
    int s0, d0, busy_bad;
    s0 = n_swr;
    d0 = n_dwr;
    busy_bad = 0;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hFF);
      if (busy !== 1'b0) busy_bad++;
    end
    check16("sat_err_count", {8'd0, err_count}, 16'd255);
    check16("sat_busy", 16'(busy_bad), 16'd0);
    check16("sat_no_writes", 16'((n_swr - s0) + (n_dwr - d0)), 16'd0);
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = n_swr;
    send_byte(8'h45);
    send_byte(8'h12);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, busy, sfifo_wrreq} !== 3'b100 || sfifo_data !== '0) begin
      n_fails++;
      $display("FAIL mid_reset_state: {rdy,busy,swr}=%b sfifo=%h, required 100 and 0",
               {in_ready, busy, sfifo_wrreq}, sfifo_data);
    end
    check16("mid_reset_stim", stim_count, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    sq.push_back({24'h010203, 5'd0, 1'b0});
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    drain("mid");
    check16("mid_writes", 16'(n_swr - s0), 16'd1);
    check16("mid_stim_count", stim_count, 16'd1);
  endtask

  initial begin
    rst           = 1'b1;
    in_data       = 8'h00;
    in_valid      = 1'b0;
    sfifo_wrfull  = 1'b0;
    dififo_wrfull = 1'b0;
    test_reset();
    test_stim();
    test_cmd();
    test_full();
    test_err();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
